// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline front end.
package mips_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {IDLE, RUN, WAIT, FLUSH} fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] ir;
    logic [XLEN-1:0] pc4;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of fetched {instruction, pc+4} pairs that absorbs responses
// arriving while decode is stalled.
module fetch_buffer
  import mips_pkg::*;
(
  input  logic         clock,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic [1:0]   count
);
  fetch_entry_t r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;
  logic         w_do_pop;
  logic         w_do_push;

  assign w_do_pop  = pop && (r_count != 2'd0);
  assign w_do_push = push && ((r_count != 2'd2) || w_do_pop);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (clear) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_do_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_do_pop)  r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, w_do_push} - {1'b0, w_do_pop};
    end
  end

  // Storage carries no reset; occupancy is tracked solely by r_count.
  always_ff @(posedge clock) begin
    if (w_do_push && !clear) r_mem[r_wr_ptr] <= din;
  end

  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;
endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, single-outstanding imem request control,
// response buffering and the IF/ID pipeline register.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] ifid_ir,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid
);
  generate
    if (BUF_DEPTH != 2) begin : g_depth_check
      $error("fetch_stage supports BUF_DEPTH == 2 only");
    end
  endgenerate

  fetch_state_t r_state, w_state_nxt;
  logic [31:0]  r_pc, r_rsp_pc4, r_ifid_ir, r_ifid_pc4;
  logic         r_outstanding, r_discard, r_ifid_valid;
  logic         w_out_after, w_rsp_live, w_push, w_pop, w_req;
  logic [2:0]   w_occ_nxt;
  logic [1:0]   w_buf_count;
  fetch_entry_t w_head, w_rsp_entry;

  assign w_out_after = r_outstanding && !imem_rvalid;
  assign w_rsp_live  = imem_rvalid && r_outstanding && !r_discard && !branch_taken;
  assign w_pop       = !branch_taken && !stall && (w_buf_count != 2'd0);
  assign w_push      = w_rsp_live && (stall || (w_buf_count != 2'd0));
  // Gate on next-cycle occupancy so the response to a newly issued request always has a slot.
  assign w_occ_nxt   = {1'b0, w_buf_count} + {2'b0, w_push} - {2'b0, w_pop};
  assign w_req       = (r_state != IDLE) && !branch_taken && !w_out_after && (w_occ_nxt < 3'd2);
  assign w_rsp_entry = '{ir: imem_rdata, pc4: r_rsp_pc4};

  fetch_buffer u_buf (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (w_push),
    .pop     (w_pop),
    .clear   (branch_taken),
    .din     (w_rsp_entry),
    .head    (w_head),
    .count   (w_buf_count)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_pc          <= RESET_PC;
      r_outstanding <= 1'b0;
      r_discard     <= 1'b0;
      r_ifid_ir     <= NOP_INSTR;
      r_ifid_pc4    <= 32'h0;
      r_ifid_valid  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (branch_taken)  r_pc <= branch_target & ~32'h3;
      else if (w_req)    r_pc <= r_pc + 32'd4;
      r_outstanding <= w_req ? 1'b1 : w_out_after;
      if (branch_taken)                  r_discard <= w_out_after;
      else if (imem_rvalid && r_discard) r_discard <= 1'b0;
      if (branch_taken) begin
        r_ifid_ir    <= NOP_INSTR;
        r_ifid_valid <= 1'b0;
      end else if (!stall) begin
        if (w_buf_count != 2'd0) begin
          r_ifid_ir    <= w_head.ir;
          r_ifid_pc4   <= w_head.pc4;
          r_ifid_valid <= 1'b1;
        end else if (w_rsp_live) begin
          r_ifid_ir    <= imem_rdata;
          r_ifid_pc4   <= r_rsp_pc4;
          r_ifid_valid <= 1'b1;
        end else begin
          r_ifid_ir    <= NOP_INSTR;
          r_ifid_valid <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_req) r_rsp_pc4 <= r_pc + 32'd4;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:  w_state_nxt = RUN;
      RUN: begin
        if (branch_taken && w_out_after) w_state_nxt = FLUSH;
        else if (w_out_after)            w_state_nxt = WAIT;
      end
      WAIT: begin
        if (branch_taken && w_out_after) w_state_nxt = FLUSH;
        else if (imem_rvalid)            w_state_nxt = RUN;
      end
      FLUSH: begin
        if (imem_rvalid) w_state_nxt = RUN;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign imem_req   = w_req;
  assign imem_addr  = r_pc;
  assign pc         = r_pc;
  assign ifid_ir    = r_ifid_ir;
  assign ifid_pc4   = r_ifid_pc4;
  assign ifid_valid = r_ifid_valid;
endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: variable-latency memory model feeds an
// expected-instruction queue that is compared as IF/ID loads.
module tb_fetch_stage;
  logic        clock, reset_n, stall, branch_taken;
  logic [31:0] branch_target, imem_addr, imem_rdata, pc, ifid_ir, ifid_pc4;
  logic        imem_req, imem_rvalid, ifid_valid;

  fetch_stage dut (
    .clock(clock), .reset_n(reset_n), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .pc(pc), .ifid_ir(ifid_ir), .ifid_pc4(ifid_pc4), .ifid_valid(ifid_valid)
  );

  typedef struct packed {logic [31:0] ir; logic [31:0] pc4;} exp_t;
  exp_t sbq[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   lat      = 1;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [7:0] idx;
    idx = a[9:2];
    if (idx == 8'd0) return 32'h8c08_0000;
    if (idx == 8'd1) return 32'h8c09_0004;
    return 32'h2108_0000 | {24'h0, idx};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_valid(input string tag, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clock);
      if (ifid_valid) ok = 1'b1;
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  task automatic do_reset(input int new_lat);
    tick();
    reset_n = 1'b0;
    lat = new_lat;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  // Memory model: one response per accepted request after lat cycles, in order.
  initial begin
    logic        req_s, rv_s, br_s;
    logic [31:0] addr_s, raddr;
    int          busy, cnt;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'hDEAD_BEEF;
    busy = 0; cnt = 0; raddr = 0;
    forever begin
      @(negedge clock);
      req_s = imem_req; addr_s = imem_addr; rv_s = imem_rvalid; br_s = branch_taken;
      if (reset_n && req_s) check("one_outstanding", 32'(busy != 0 && !rv_s), 32'd0);
      @(posedge clock);
      #1;
      if (!reset_n) begin
        busy = 0;
        imem_rvalid = 1'b0;
        sbq.delete();
      end else begin
        if (rv_s) busy = 0;
        if (br_s) sbq.delete();
        if (req_s) begin
          busy = 1; cnt = lat; raddr = addr_s;
          sbq.push_back({mem_word(addr_s), addr_s + 32'd4});
        end
        if (busy != 0 && cnt > 0) cnt--;
        imem_rvalid = (busy != 0 && cnt == 0);
        imem_rdata  = imem_rvalid ? mem_word(raddr) : 32'hDEAD_BEEF;
      end
    end
  end

  // IF/ID checker: pops the scoreboard on each load, checks holds and bubbles.
  initial begin
    logic        prev_rst, prev_stall, prev_br, m_valid;
    logic [31:0] m_ir, m_pc4;
    exp_t        e;
    prev_rst = 1'b0; prev_stall = 1'b0; prev_br = 1'b0;
    m_valid = 1'b0; m_ir = 0; m_pc4 = 0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        m_ir = 0; m_pc4 = 0; m_valid = 1'b0;
      end else if (prev_rst) begin
        if (prev_br) begin
          check("br_ifid_ir", ifid_ir, 32'h0);
          check("br_ifid_valid", 32'(ifid_valid), 32'd0);
          m_ir = 0; m_valid = 1'b0;
        end else if (prev_stall) begin
          check("hold_ir", ifid_ir, m_ir);
          check("hold_valid", 32'(ifid_valid), 32'(m_valid));
          if (m_valid) check("hold_pc4", ifid_pc4, m_pc4);
        end else if (ifid_valid) begin
          check("sb_nonempty", 32'(sbq.size() != 0), 32'd1);
          if (sbq.size() != 0) begin
            e = sbq.pop_front();
            check("ifid_ir", ifid_ir, e.ir);
            check("ifid_pc4", ifid_pc4, e.pc4);
            m_ir = e.ir; m_pc4 = e.pc4;
          end
          m_valid = 1'b1;
        end else begin
          check("bubble_ir", ifid_ir, 32'h0);
          m_ir = 0; m_valid = 1'b0;
        end
      end
      prev_rst = reset_n; prev_stall = stall; prev_br = branch_taken;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit found;
    reset_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    lat = 1;
    // Reset state
    repeat (3) tick();
    @(negedge clock);
    check("rst_pc", pc, 32'h0);
    check("rst_ir", ifid_ir, 32'h0);
    check("rst_pc4", ifid_pc4, 32'h0);
    check("rst_valid", 32'(ifid_valid), 32'd0);
    check("rst_req", 32'(imem_req), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    @(negedge clock);
    check("first_req", 32'(imem_req), 32'd1);
    check("first_addr", imem_addr, 32'h0);

    // L=1 stream
    wait_valid("stream_first", 10);
    check("stream_ir0", ifid_ir, 32'h8c08_0000);
    check("stream_pc4_0", ifid_pc4, 32'd4);
    @(negedge clock);
    check("stream_ir1", ifid_ir, 32'h8c09_0004);
    check("stream_pc4_1", ifid_pc4, 32'd8);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("stream_rate", 32'(ifid_valid), 32'd1);
    end

    // Stall three cycles: buffer fills and requests stop
    tick();
    stall = 1'b1;
    tick();
    tick();
    @(negedge clock);
    check("stall_full_no_req", 32'(imem_req), 32'd0);
    tick();
    stall = 1'b0;
    repeat (10) tick();

    // Branch at 36 with a response in flight, L=2
    do_reset(2);
    found = 1'b0;
    for (int i = 0; i < 80 && !found; i++) begin
      tick();
      if (ifid_valid && ifid_pc4 == 32'd40) found = 1'b1;
    end
    check("br_reach_36", 32'(found), 32'd1);
    branch_taken = 1'b1;
    branch_target = 32'd63;
    tick();
    branch_taken = 1'b0;
    @(negedge clock);
    check("br_pc", pc, 32'd60);
    wait_valid("br_target_arrives", 20);
    check("br_target_ir", ifid_ir, mem_word(32'd60));
    check("br_target_pc4", ifid_pc4, 32'd64);

    // L=3: bubbles between instructions
    do_reset(3);
    for (int k = 0; k < 3; k++) begin
      wait_valid("l3_valid", 20);
      @(negedge clock);
      check("l3_bubble", 32'(ifid_valid), 32'd0);
    end

    // Reset in the middle of a flush with the buffer occupied
    tick();
    stall = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clock);
      if (imem_req) found = 1'b1;
    end
    check("flush_req_seen", 32'(found), 32'd1);
    tick();
    branch_taken = 1'b1;
    branch_target = 32'h100;
    tick();
    branch_taken = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_pc", pc, 32'h0);
    check("async_rst_ir", ifid_ir, 32'h0);
    check("async_rst_pc4", ifid_pc4, 32'h0);
    check("async_rst_valid", 32'(ifid_valid), 32'd0);
    check("async_rst_req", 32'(imem_req), 32'd0);
    tick();
    tick();
    stall = 1'b0;
    reset_n = 1'b1;
    wait_valid("restart_valid", 20);
    check("restart_ir", ifid_ir, 32'h8c08_0000);
    check("restart_pc4", ifid_pc4, 32'd4);
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
